subtractor_n_seq: RTL

// - Multi-cycle N-bit subtractor: diff = a - b - b_in, with borrow-out. It is the inverse of the combinational N-bit adder.
// - Processes CHUNK bits per cycle, so N-bit arithmetic closes timing at small area.
// - Uses valid/ready handshakes on both sides. Sits in the datapath between an operand producer and a result consumer.

---
 rtl/subtractor_n_seq.sv | 115 +++++++++++
 1 files changed

// File: rtl/subtractor_n_seq.sv
// Multi-cycle N-bit subtractor (diff = a - b - b_in), CHUNK bits per BUSY cycle, valid/ready on both sides.
// Optional signed flags (ovf, neg) are built only when SUB_SIGNED_FLAGS_EN is defined.
module subtractor_n_seq #(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         b_in,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [N-1:0] diff,
    output logic         b_out
`ifdef SUB_SIGNED_FLAGS_EN
    ,
    output logic         ovf,
    output logic         neg
`endif
);

    localparam int NCH = N / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state, state_nx;
    logic [N-1:0]     a_r, b_r;
    logic             brw;
    logic [CW-1:0]    cnt;

    logic [CHUNK-1:0] d_k;
    logic             brw_nx;
    logic [N-1:0]     diff_nx;
    logic             last;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        i_ready  = 1'b0;
        o_valid  = 1'b0;
        {brw_nx, d_k} = {1'b0, a_r[cnt*CHUNK +: CHUNK]}
                      - {1'b0, b_r[cnt*CHUNK +: CHUNK]}
                      - {{CHUNK{1'b0}}, brw};
        // Full next diff is needed so the flags see the final top chunk at the DONE transition.
        diff_nx = diff;
        diff_nx[cnt*CHUNK +: CHUNK] = d_k;
        last = (cnt == CW'(NCH - 1));
        case (state)
            IDLE: begin
                i_ready = 1'b1;
                if (i_valid) state_nx = BUSY;
            end
            BUSY: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                if (o_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            b_out <= 1'b0;
`ifdef SUB_SIGNED_FLAGS_EN
            ovf   <= 1'b0;
            neg   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_r <= a;
                        b_r <= b;
                        brw <= b_in;
                        cnt <= '0;
                    end
                end
                BUSY: begin
                    diff <= diff_nx;
                    brw  <= brw_nx;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        b_out <= brw_nx;
`ifdef SUB_SIGNED_FLAGS_EN
                        ovf   <= (a_r[N-1] != b_r[N-1]) && (diff_nx[N-1] != a_r[N-1]);
                        neg   <= diff_nx[N-1];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
